// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the non-pipelined LEGv8 core.
// Owns the program counter, hides the one-cycle read latency of the
// synchronous instruction memory, buffers one instruction across consumer
// stalls, squashes in-flight fetches on redirects and traps bad addresses.
module fetch_sequencer #(
   parameter int unsigned        WORD_W    = 64,
   parameter int unsigned        INSTR_LEN = 32,
   parameter logic [WORD_W-1:0]  RESET_PC  = '0,
   parameter int unsigned        SIZE      = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [WORD_W-1:0]    mem_address,
   input  logic [INSTR_LEN-1:0] mem_instruction,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [WORD_W-1:0]    redirect_pc,
   output logic [INSTR_LEN-1:0] instr_out,
   output logic [WORD_W-1:0]    pc_out,
   output logic                 instr_valid,
   output logic                 fault,
   output logic [WORD_W-1:0]    fault_pc,
   output logic [31:0]          fetch_count
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_STALLED,
      ST_FAULT
   } state_e;

   localparam logic [WORD_W-1:0] SIZE_W = WORD_W'(SIZE);
   localparam logic [WORD_W-1:0] STEP_W = WORD_W'(4);

   state_e                 state_q, state_d;
   logic [WORD_W-1:0]      pc_q, pc_d;
   logic [WORD_W-1:0]      rsp_pc_q, rsp_pc_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   hold_valid_q, hold_valid_d;
   logic [INSTR_LEN-1:0]   hold_instr_q, hold_instr_d;
   logic [WORD_W-1:0]      fault_pc_q, fault_pc_d;
   logic [31:0]            fetch_count_q, fetch_count_d;

   logic                   accept;
   logic                   advance;
   logic                   bad_addr;

   // Output view: memory address tracks the PC, the hold register overrides
   // the raw memory data while a stalled instruction is being presented.
   always_comb begin
      mem_address = pc_q;
      pc_out      = rsp_pc_q;
      instr_valid = rsp_valid_q && (state_q != ST_FAULT);
      instr_out   = hold_valid_q ? hold_instr_q : mem_instruction;
      fault       = (state_q == ST_FAULT);
      fault_pc    = fault_pc_q;
      fetch_count = fetch_count_q;
   end

   // Handshake and address-check terms shared by the next-state logic.
   always_comb begin
      accept   = instr_valid && !stall;
      advance  = !stall || !rsp_valid_q;
      bad_addr = (pc_q[1:0] != 2'b00) || ((pc_q >> 2) >= SIZE_W);
   end

   // Next-state logic, in priority order redirect, fault, stall, advance.
   always_comb begin
      // NOTE: every signal gets a hold-value default first so no path through
      // the priority chain leaves it unassigned and infers a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      rsp_valid_d   = rsp_valid_q;
      hold_valid_d  = hold_valid_q;
      hold_instr_d  = hold_instr_q;
      fault_pc_d    = fault_pc_q;
      fetch_count_d = fetch_count_q + {31'd0, accept};

      if (redirect) begin
         pc_d         = redirect_pc;
         rsp_valid_d  = 1'b0;
         hold_valid_d = 1'b0;
         state_d      = ST_RUN;
      end else if (state_q == ST_FAULT) begin
         // Parked until a redirect or reset.
      end else if (advance) begin
         if (bad_addr) begin
            state_d      = ST_FAULT;
            fault_pc_d   = pc_q;
            rsp_valid_d  = 1'b0;
            hold_valid_d = 1'b0;
         end else begin
            rsp_pc_d     = pc_q;
            rsp_valid_d  = 1'b1;
            pc_d         = pc_q + STEP_W;
            hold_valid_d = 1'b0;
            state_d      = ST_RUN;
         end
      end else begin
         // Stalled with a live response: capture the first stalled value only;
         // the memory keeps reading the successor at pc_q.
         if (!hold_valid_q) begin
            hold_instr_d = mem_instruction;
            hold_valid_d = 1'b1;
         end
         state_d = ST_STALLED;
      end
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         rsp_pc_q      <= '0;
         rsp_valid_q   <= 1'b0;
         hold_valid_q  <= 1'b0;
         fault_pc_q    <= '0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         rsp_valid_q   <= rsp_valid_d;
         hold_valid_q  <= hold_valid_d;
         fault_pc_q    <= fault_pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // Hold data register.
   always_ff @(posedge clk) begin
      // NOTE: the data word needs no reset; hold_valid_q gates every use of it.
      hold_instr_q <= hold_instr_d;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: a synchronous memory
// model feeds the DUT and a queue of expected (pc, instr) pairs is filled
// whenever reset or redirect stimulus is driven and drained on acceptance.
module tb_fetch_sequencer;

   localparam int unsigned WORD_W    = 64;
   localparam int unsigned INSTR_LEN = 32;
   localparam int unsigned SIZE      = 1024;
   localparam logic [63:0] RESET_PC  = 64'h0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [WORD_W-1:0]    mem_address;
   logic [INSTR_LEN-1:0] mem_instruction;
   logic                 stall;
   logic                 redirect;
   logic [WORD_W-1:0]    redirect_pc;
   logic [INSTR_LEN-1:0] instr_out;
   logic [WORD_W-1:0]    pc_out;
   logic                 instr_valid;
   logic                 fault;
   logic [WORD_W-1:0]    fault_pc;
   logic [31:0]          fetch_count;

   logic [31:0] mem [SIZE];
   exp_t        exp_q [$];
   int          checks   = 0;
   int          failures = 0;

   fetch_sequencer #(
      .WORD_W    (WORD_W),
      .INSTR_LEN (INSTR_LEN),
      .RESET_PC  (RESET_PC),
      .SIZE      (SIZE)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_address     (mem_address),
      .mem_instruction (mem_instruction),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .instr_out       (instr_out),
      .pc_out          (pc_out),
      .instr_valid     (instr_valid),
      .fault           (fault),
      .fault_pc        (fault_pc),
      .fetch_count     (fetch_count)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory, one-cycle read latency.
   always @(posedge clk) mem_instruction <= mem[mem_address[11:2]];

   function automatic logic [31:0] word_at(input logic [63:0] addr);
      return mem[addr[11:2]];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check the presented instruction against
   // the scoreboard, update the scoreboard for squash/refill, then clock.
   task automatic step(input logic rst, input logic stl, input logic rd,
                       input logic [63:0] rpc, input logic exp_v,
                       input int npush, input string tag);
      logic [63:0] base;
      exp_t        e;
      reset       = rst;
      stall       = stl;
      redirect    = rd;
      redirect_pc = rpc;
      chk({tag, " valid"}, {63'd0, instr_valid}, {63'd0, exp_v});
      if (exp_v) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
         end
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk({tag, " pc_out"}, pc_out, e.pc);
            chk({tag, " instr_out"}, {32'd0, instr_out}, {32'd0, e.instr});
            if (!stl) void'(exp_q.pop_front());
         end
      end
      if (rst || rd) begin
         exp_q.delete();
         base = rst ? RESET_PC : rpc;
         for (int i = 0; i < npush; i++) begin
            e.pc    = base + 64'(4 * i);
            e.instr = word_at(e.pc);
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < int'(SIZE); i++) mem[i] = 32'hC0DE_0000 + 32'(i * 3 + 1);
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

      // Reset and first fetches.
      step(1, 0, 0, 0, 0, 0, "rst0");
      chk("rst valid", {63'd0, instr_valid}, 64'd0);
      chk("rst fault", {63'd0, fault}, 64'd0);
      chk("rst count", {32'd0, fetch_count}, 64'd0);
      chk("rst mem_address", mem_address, RESET_PC);
      chk("rst fault_pc", fault_pc, 64'd0);
      step(1, 0, 0, 0, 0, 5, "rst1");
      step(0, 0, 0, 0, 0, 0, "c0");
      step(0, 0, 0, 0, 1, 0, "c1");
      step(0, 0, 0, 0, 1, 0, "c2");
      step(0, 0, 0, 0, 1, 0, "c3");
      step(0, 0, 0, 0, 1, 0, "c4");
      chk("count after 4", {32'd0, fetch_count}, 64'd4);

      // Restart at 0, then stall three cycles on B.
      step(0, 0, 1, 64'h0, 1, 5, "c5");
      step(0, 0, 0, 0, 0, 0, "c6 bubble");
      step(0, 0, 0, 0, 1, 0, "c7");
      step(0, 1, 0, 0, 1, 0, "c8 stall1");
      step(0, 1, 0, 0, 1, 0, "c9 stall2");
      step(0, 1, 0, 0, 1, 0, "c10 stall3");
      step(0, 0, 0, 0, 1, 0, "c11 release");
      step(0, 0, 0, 0, 1, 0, "c12");
      step(0, 0, 0, 0, 1, 0, "c13");
      chk("count after stall", {32'd0, fetch_count}, 64'd9);

      // Redirect to 0x40 while pc_out=8.
      step(0, 0, 1, 64'h0, 1, 3, "c14");
      step(0, 0, 0, 0, 0, 0, "c15 bubble");
      step(0, 0, 0, 0, 1, 0, "c16");
      step(0, 0, 0, 0, 1, 0, "c17");
      step(0, 0, 1, 64'h40, 1, 3, "c18 redirect");
      step(0, 0, 0, 0, 0, 0, "c19 bubble");
      step(0, 0, 0, 0, 1, 0, "c20");
      step(0, 0, 0, 0, 1, 0, "c21");

      // Redirect during a stall; held word must never reappear.
      step(0, 1, 0, 0, 1, 0, "c22 stall");
      step(0, 1, 1, 64'h80, 1, 3, "c23 stall redirect");
      step(0, 1, 0, 0, 0, 0, "c24 bubble");
      step(0, 0, 0, 0, 1, 0, "c25");
      step(0, 0, 0, 0, 1, 0, "c26");

      // Misaligned redirect target.
      step(0, 0, 1, 64'h42, 1, 0, "c27 redirect 0x42");
      chk("c28 fault", {63'd0, fault}, 64'd0);
      step(0, 0, 0, 0, 0, 0, "c28");
      chk("c29 fault", {63'd0, fault}, 64'd1);
      chk("c29 fault_pc", fault_pc, 64'h42);
      chk("c29 mem_address frozen", mem_address, 64'h42);
      step(0, 0, 0, 0, 0, 0, "c29");
      chk("c30 fault sticky", {63'd0, fault}, 64'd1);
      step(0, 0, 1, 64'h0, 0, 2, "c30 recover");
      chk("c31 fault cleared", {63'd0, fault}, 64'd0);
      step(0, 0, 0, 0, 0, 0, "c31");
      step(0, 0, 0, 0, 1, 0, "c32");

      // Out-of-range redirect target (first word past the memory).
      step(0, 0, 1, 64'(SIZE * 4), 1, 0, "c33 redirect oob");
      step(0, 0, 0, 0, 0, 0, "c34");
      chk("c35 fault", {63'd0, fault}, 64'd1);
      chk("c35 fault_pc", fault_pc, 64'(SIZE * 4));
      step(0, 0, 1, 64'h0, 0, 3, "c35 recover");
      chk("c36 fault cleared", {63'd0, fault}, 64'd0);
      step(0, 0, 0, 0, 0, 0, "c36");
      step(0, 0, 0, 0, 1, 0, "c37");
      step(0, 0, 0, 0, 1, 0, "c38");
      step(0, 1, 0, 0, 1, 0, "c39 stall");

      // Reset in the middle of a stall.
      chk("c40 count before reset", {32'd0, fetch_count}, 64'd22);
      step(1, 1, 0, 0, 1, 2, "c40 reset");
      chk("c41 count", {32'd0, fetch_count}, 64'd0);
      chk("c41 mem_address", mem_address, RESET_PC);
      chk("c41 fault", {63'd0, fault}, 64'd0);
      step(0, 0, 0, 0, 0, 0, "c41");
      step(0, 0, 0, 0, 1, 0, "c42");
      step(0, 0, 0, 0, 1, 0, "c43");
      chk("c44 count", {32'd0, fetch_count}, 64'd2);
      chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
